// File: rtl/addsub_stream_pkg.sv
// Shared types and the arithmetic core for the streaming adder/subtractor.
// addsub_calc is the single definition of result/overflow behaviour.
package addsub_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Widest operand the shared function handles; callers zero-extend into it.
   localparam int unsigned CALC_W = 64;

   // Returns {ovf, result}; only the low `width` result bits are meaningful.
   function automatic logic [CALC_W:0] addsub_calc(
      input logic [CALC_W-1:0] a,
      input logic [CALC_W-1:0] b,
      input op_e               op,
      input logic              is_signed,
      input logic              sat,
      input int unsigned       width
   );
      logic [CALC_W:0]   one_w;
      logic [CALC_W:0]   mask_w;
      logic [CALC_W:0]   full;
      logic [CALC_W-1:0] mask;
      logic [CALC_W-1:0] sign_m;
      logic [CALC_W-1:0] a_m;
      logic [CALC_W-1:0] b_m;
      logic [CALC_W-1:0] res;
      logic              sa;
      logic              sb;
      logic              sr;
      logic              ovf;

      one_w  = {{CALC_W{1'b0}}, 1'b1};
      mask_w = (one_w << width) - one_w;
      mask   = mask_w[CALC_W-1:0];
      sign_m = mask ^ (mask >> 1);
      a_m    = a & mask;
      b_m    = b & mask;

      if (op == OP_SUB) full = {1'b0, a_m} - {1'b0, b_m};
      else              full = {1'b0, a_m} + {1'b0, b_m};

      res = full[CALC_W-1:0] & mask;
      sa  = |(a_m & sign_m);
      sb  = |(b_m & sign_m);
      sr  = |(res & sign_m);

      if (is_signed) begin
         if (op == OP_SUB) ovf = (sa != sb) && (sr != sa);
         else              ovf = (sa == sb) && (sr != sa);
      end else begin
         // Carry is any bit at or above `width`; borrow is a plain magnitude compare.
         if (op == OP_SUB) ovf = (a_m < b_m);
         else              ovf = |(full & ~mask_w);
      end

      if (ovf && sat) begin
         if (is_signed)        res = sa ? sign_m : (mask >> 1);
         else if (op == OP_SUB) res = '0;
         else                  res = mask;
      end

      return {ovf, res};
   endfunction

endpackage

// File: rtl/addsub_stream_fifo.sv
// Synchronous FIFO with occupancy count; holds {ovf, result} entries.
// DEPTH need not be a power of two: pointers wrap explicitly at DEPTH-1.
module addsub_fifo #(
   parameter int unsigned DW    = 33,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [DW-1:0]              wdata_i,
   output logic [DW-1:0]              rdata_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0]    mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] rd_ptr_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: an empty FIFO never exposes it.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/addsub_stream.sv
// Streaming adder/subtractor: valid/ready in, buffered valid/ready out.
// WIDTH is limited to addsub_pkg::CALC_W bits.
module addsub_stream
   import addsub_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned SIGNED   = 1,
   parameter int unsigned SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_ovf
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   state_e           state_q;
   logic [CALC_W:0]  calc;
   logic [WIDTH:0]   wr_entry;
   logic [WIDTH:0]   rd_entry;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             calc_unused;
   logic             fifo_unused;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INIT;
      end else begin
         case (state_q)
            INIT:    state_q <= RUN;
            RUN:     state_q <= RUN;
            default: state_q <= INIT;
         endcase
      end
   end

   // Registered state and count only; out_ready never reaches in_ready.
   assign in_ready  = (state_q == RUN) && (count < CNT_W'(DEPTH));
   assign push      = in_valid && in_ready;
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;

   always_comb begin
      calc = addsub_calc(CALC_W'(in_a), CALC_W'(in_b), op_e'(in_op),
                         (SIGNED != 0), (SATURATE != 0), WIDTH);
   end

   assign wr_entry    = {calc[CALC_W], calc[WIDTH-1:0]};
   assign calc_unused = ^calc;
   assign fifo_unused = full;

   addsub_fifo #(
      .DW    (WIDTH + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wr_entry),
      .rdata_o (rd_entry),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
   );

   assign out_data = rd_entry[WIDTH-1:0];
   assign out_ovf  = rd_entry[WIDTH];

endmodule

// File: tb/tb_addsub_stream.sv
// Scoreboard bench for addsub_stream: three 8-bit instances covering
// unsigned wrap, signed saturation and a DEPTH=3 signed-wrap buffer.
module tb_addsub_stream;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] iv;
   logic [2:0] iop;
   logic [2:0] ordy;
   logic [7:0] ia [3];
   logic [7:0] ib [3];
   wire  [2:0] irdy;
   wire  [2:0] ov;
   wire  [2:0] oovf;
   wire  [7:0] od [3];

   int         n_cmp = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         pops [3] = '{0, 0, 0};
   int         occ2 = 0;
   int         max_occ2 = 0;
   bit         done = 1'b0;
   bit         wrap_done = 1'b0;
   logic [8:0] q0 [$];
   logic [8:0] q1 [$];
   logic [8:0] q2 [$];

   always #5 clk = ~clk;

   addsub_stream #(.WIDTH(8), .DEPTH(4), .SIGNED(0), .SATURATE(0)) u_uns (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
      .in_a(ia[0]), .in_b(ib[0]), .in_op(iop[0]), .out_valid(ov[0]),
      .out_ready(ordy[0]), .out_data(od[0]), .out_ovf(oovf[0]));

   addsub_stream #(.WIDTH(8), .DEPTH(4), .SIGNED(1), .SATURATE(1)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
      .in_a(ia[1]), .in_b(ib[1]), .in_op(iop[1]), .out_valid(ov[1]),
      .out_ready(ordy[1]), .out_data(od[1]), .out_ovf(oovf[1]));

   addsub_stream #(.WIDTH(8), .DEPTH(3), .SIGNED(1), .SATURATE(0)) u_wrap (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
      .in_a(ia[2]), .in_b(ib[2]), .in_op(iop[2]), .out_valid(ov[2]),
      .out_ready(ordy[2]), .out_data(od[2]), .out_ovf(oovf[2]));

   // Independent 8-bit reference using plain integer arithmetic.
   function automatic logic [8:0] model(input int a, input int b, input logic op,
                                        input bit sgn, input bit sat);
      int r;
      int lo;
      int hi;
      if (sgn) begin
         if (a > 127) a = a - 256;
         if (b > 127) b = b - 256;
         lo = -128;
         hi = 127;
      end else begin
         lo = 0;
         hi = 255;
      end
      r = op ? (a - b) : (a + b);
      if (r < lo || r > hi) begin
         if (sat) r = (r < lo) ? lo : hi;
         return {1'b1, r[7:0]};
      end
      return {1'b0, r[7:0]};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic q_push(input int k, input logic [8:0] e);
      case (k)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   function automatic int q_size(input int k);
      case (k)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic q_pop(input int k, output logic [8:0] e, output bit ok);
      ok = (q_size(k) != 0);
      e  = '0;
      if (ok) begin
         case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
         endcase
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic push(input int k, input logic [7:0] a, input logic [7:0] b,
                       input logic op, input logic [8:0] e);
      int t;
      t = 0;
      ia[k] = a; ib[k] = b; iop[k] = op; iv[k] = 1'b1;
      @(negedge clk);
      while (!irdy[k] && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!irdy[k]) begin
         n_cmp++;
         n_fail++;
         $display("FAIL push_timeout dut%0d: in_ready stayed 0 for %0d cycles, required 1", k, t);
      end else begin
         q_push(k, e);
      end
      @(posedge clk);
      #1;
      iv[k] = 1'b0;
   endtask

   task automatic wait_drain(input int k);
      int t;
      t = 0;
      while (q_size(k) != 0 && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      check($sformatf("drain_dut%0d", k), q_size(k), 0);
   endtask

   initial begin
      iv = '0; iop = '0; ordy = '0; rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin ia[k] = '0; ib[k] = '0; end
      fork
         begin : monitor
            logic [8:0] e;
            bit         ok;
            while (!done) begin
               @(negedge clk);
               cyc++;
               if (rst_n) begin
                  for (int k = 0; k < 3; k++) begin
                     if (ov[k] && ordy[k]) begin
                        pops[k]++;
                        q_pop(k, e, ok);
                        if (!ok) begin
                           n_cmp++;
                           n_fail++;
                           $display("FAIL unexpected_out dut%0d: got %0d expected none", k, {oovf[k], od[k]});
                        end else begin
                           check($sformatf("result_dut%0d", k), {oovf[k], od[k]}, e);
                        end
                     end
                  end
                  occ2 = occ2 + int'(iv[2] && irdy[2]) - int'(ov[2] && ordy[2]);
                  if (occ2 > max_occ2) max_occ2 = occ2;
               end
            end
         end
         begin : stimulus
            int t0;
            bit stale;
            logic [7:0] a;
            logic [7:0] b;
            logic       op;

            // Reset values, then INIT -> RUN on the first edge after release.
            @(negedge clk);
            check("rst_in_ready", irdy[0], 0);
            check("rst_out_valid", ov[0], 0);
            check("rst_out_data", od[0], 0);
            check("rst_out_ovf", oovf[0], 0);
            rst_n = 1'b1;
            #1 check("init_in_ready", irdy[0], 0);
            @(posedge clk);
            #1 check("run_in_ready", irdy[0], 1);

            // Unsigned wrap, with a 1-cycle latency check on the first pair.
            push(0, 8'd200, 8'd100, 1'b0, {1'b1, 8'd44});
            @(negedge clk);
            check("latency_out_valid", ov[0], 1);
            @(posedge clk);
            #1 ordy[0] = 1'b1;
            push(0, 8'd5,   8'd7, 1'b1, {1'b1, 8'd254});
            push(0, 8'd7,   8'd5, 1'b1, {1'b0, 8'd2});
            push(0, 8'd255, 8'd1, 1'b0, {1'b1, 8'd0});
            push(0, 8'd0,   8'd0, 1'b1, {1'b0, 8'd0});
            wait_drain(0);

            // Signed saturation.
            ordy[1] = 1'b1;
            push(1, 8'd100, 8'd100, 1'b0, {1'b1, 8'd127});
            push(1, 8'd156, 8'd100, 1'b1, {1'b1, 8'd128});
            push(1, 8'd253, 8'd5,   1'b0, {1'b0, 8'd2});
            push(1, 8'd127, 8'd255, 1'b1, {1'b1, 8'd127});
            push(1, 8'd128, 8'd255, 1'b0, {1'b1, 8'd128});
            push(1, 8'd50,  8'd70,  1'b1, {1'b0, 8'd236});
            wait_drain(1);

            // Back-pressure: four accepts fill the buffer, the rest wait.
            ordy[0] = 1'b0;
            push(0, 8'd1, 8'd2, 1'b0, {1'b0, 8'd3});
            push(0, 8'd9, 8'd4, 1'b1, {1'b0, 8'd5});
            push(0, 8'd128, 8'd128, 1'b0, {1'b1, 8'd0});
            push(0, 8'd3, 8'd4, 1'b1, {1'b1, 8'd255});
            check("full_in_ready", irdy[0], 0);
            repeat (3) @(posedge clk);
            #1 check("full_hold_in_ready", irdy[0], 0);
            fork
               begin
                  push(0, 8'd10, 8'd20, 1'b0, {1'b0, 8'd30});
                  push(0, 8'd20, 8'd10, 1'b1, {1'b0, 8'd10});
               end
               begin
                  repeat (2) @(posedge clk);
                  #1 ordy[0] = 1'b1;
               end
            join
            wait_drain(0);
            check("bp_pop_count", pops[0], 11);

            // Full throughput: one accept per cycle, drained one cycle later.
            t0 = cyc;
            for (int i = 0; i < 100; i++) begin
               a  = 8'($urandom_range(0, 255));
               b  = 8'($urandom_range(0, 255));
               op = 1'($urandom_range(0, 1));
               push(0, a, b, op, model(int'(a), int'(b), op, 1'b0, 1'b0));
            end
            check("tput_cycles", cyc - t0, 100);
            @(posedge clk);
            #1 check("tput_pop_count", pops[0], 111);

            // DEPTH=3 pointer wrap under mostly-stalled out_ready.
            fork
               begin
                  for (int i = 0; i < 10; i++) begin
                     a  = 8'($urandom_range(0, 255));
                     b  = 8'($urandom_range(0, 255));
                     op = 1'(i % 2);
                     push(2, a, b, op, model(int'(a), int'(b), op, 1'b1, 1'b0));
                  end
                  wrap_done = 1'b1;
               end
               begin
                  while (!wrap_done) begin
                     @(posedge clk);
                     #1 ordy[2] = ($urandom_range(0, 3) == 0);
                  end
               end
            join
            ordy[2] = 1'b1;
            wait_drain(2);
            check("wrap_pop_count", pops[2], 10);
            check("wrap_count_le_depth", int'(max_occ2 <= 3), 1);

            // Reset with three results buffered.
            ordy[0] = 1'b0;
            push(0, 8'd11, 8'd22, 1'b0, {1'b0, 8'd33});
            push(0, 8'd44, 8'd55, 1'b0, {1'b0, 8'd99});
            push(0, 8'd66, 8'd77, 1'b1, {1'b1, 8'd245});
            #2 rst_n = 1'b0;
            #1 check("midrst_out_valid", ov[0], 0);
            check("midrst_in_ready", irdy[0], 0);
            check("midrst_out_data", od[0], 0);
            q0.delete();
            @(negedge clk);
            rst_n = 1'b1;
            ordy[0] = 1'b1;
            #1 check("midrst_init_in_ready", irdy[0], 0);
            @(posedge clk);
            #1 check("midrst_run_in_ready", irdy[0], 1);
            stale = 1'b0;
            repeat (4) begin
               @(negedge clk);
               if (ov[0]) stale = 1'b1;
            end
            check("midrst_no_stale", int'(stale), 0);
            @(posedge clk);
            #1;
            push(0, 8'd10, 8'd20, 1'b0, {1'b0, 8'd30});
            wait_drain(0);

            done = 1'b1;
         end
      join
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
